// File: rtl/traffic_signal_colors_pkg.sv
// rtl/traffic_signal_colors_pkg.sv - signal head color encoding shared with the controller
package traffic_signal_colors_pkg;

  // Encoding 2'd3 is not a legal color; the monitor treats it as an invalid output.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } color_e;

endpackage

// File: rtl/traffic_signal_conflict_monitor_if.sv
// rtl/traffic_signal_conflict_monitor_if.sv - signal head bundle and fault status seen by the conflict monitor
interface traffic_signal_conflict_monitor_if;
  import traffic_signal_colors_pkg::*;

  // NS vehicle channels 0-3
  color_e      signal_sb;
  color_e      signal_sb_turn;
  color_e      signal_nb;
  color_e      signal_nb_turn;
  // EW vehicle channels 4-7
  color_e      signal_wb;
  color_e      signal_wb_turn;
  color_e      signal_eb;
  color_e      signal_eb_turn;
  // pedestrian channels 8, 9
  color_e      ped_signal_ns;
  color_e      ped_signal_ew;
  // operator acknowledge
  logic        fault_clear;
  // monitor status
  logic        flash_en;
  logic        fault;
  logic [2:0]  fault_code;
  logic [3:0]  fault_channel;
  logic [7:0]  fault_count;

  // Controller / cabinet side: drives the heads and the acknowledge, observes status.
  modport master (
    output signal_sb, signal_sb_turn, signal_nb, signal_nb_turn,
    output signal_wb, signal_wb_turn, signal_eb, signal_eb_turn,
    output ped_signal_ns, ped_signal_ew, fault_clear,
    input  flash_en, fault, fault_code, fault_channel, fault_count
  );

  // Monitor side.
  modport slave (
    input  signal_sb, signal_sb_turn, signal_nb, signal_nb_turn,
    input  signal_wb, signal_wb_turn, signal_eb, signal_eb_turn,
    input  ped_signal_ns, ped_signal_ew, fault_clear,
    output flash_en, fault, fault_code, fault_channel, fault_count
  );

endinterface

// File: rtl/traffic_signal_conflict_monitor.sv
// rtl/traffic_signal_conflict_monitor.sv - independent conflict/sequence watchdog that forces flash on a fault
module traffic_signal_conflict_monitor
  import traffic_signal_colors_pkg::*;
#(
  parameter int MIN_YELLOW       = 3,
  parameter int CONFLICT_PERSIST = 2,
  parameter int ALL_RED_CLEAR    = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  traffic_signal_conflict_monitor_if.slave   mon
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int PW = $clog2(CONFLICT_PERSIST + 1);
  localparam int AW = $clog2(ALL_RED_CLEAR + 1);

  localparam logic [1:0]    INVALID_COLOR = 2'd3;
  localparam logic [YW-1:0] YMAX          = YW'(MIN_YELLOW);

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_SKIP_Y   = 3'd2;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd3;
  localparam logic [2:0] CODE_INVALID  = 3'd4;

  typedef enum logic [1:0] {
    S_MONITOR    = 2'd0,
    S_PENDING    = 2'd1,
    S_FAULT      = 2'd2,
    S_CLEAR_WAIT = 2'd3
  } state_e;

  // Channels whose simultaneous right-of-way is unsafe; row i lists the partners of channel i.
  function automatic logic [9:0] conflict_mask(input int idx);
    logic [9:0] m;
    case (idx)
      0:       m = 10'h2F8;  // sb:      EW 4-7, nb_turn, ped_ew
      1:       m = 10'h3F4;  // sb_turn: EW 4-7, nb, ped_ns, ped_ew
      2:       m = 10'h2F2;  // nb:      EW 4-7, sb_turn, ped_ew
      3:       m = 10'h3F1;  // nb_turn: EW 4-7, sb, ped_ns, ped_ew
      4:       m = 10'h18F;  // wb:      NS 0-3, eb_turn, ped_ns
      5:       m = 10'h34F;  // wb_turn: NS 0-3, eb, ped_ns, ped_ew
      6:       m = 10'h12F;  // eb:      NS 0-3, wb_turn, ped_ns
      7:       m = 10'h31F;  // eb_turn: NS 0-3, wb, ped_ns, ped_ew
      8:       m = 10'h0FA;  // ped_ns:  1, 3, 4-7
      9:       m = 10'h0AF;  // ped_ew:  0-3, 5, 7
      default: m = 10'h000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [9:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Channel vector, index = channel number.
  logic [9:0][1:0] ch_w;
  assign ch_w = {mon.ped_signal_ew, mon.ped_signal_ns,
                 mon.signal_eb_turn, mon.signal_eb, mon.signal_wb_turn, mon.signal_wb,
                 mon.signal_nb_turn, mon.signal_nb, mon.signal_sb_turn, mon.signal_sb};

  state_e            state_q;
  logic [9:0][1:0]   prev_q, prev_d;
  logic [7:0][YW-1:0] ycnt_q, ycnt_d;
  logic [PW-1:0]     persist_q;
  logic [AW-1:0]     allred_q;
  logic              fault_q, flash_en_q;
  logic [2:0]        fault_code_q;
  logic [3:0]        fault_channel_q;
  logic [7:0]        fault_count_q;

  logic [9:0] active, invalid, conflict_hit;
  logic [7:0] skip_y, short_y;
  logic       conflict, persist_done, all_red, clear_done;
  logic [2:0] ev_code;
  logic [3:0] ev_channel;

  // Per-channel color classification, sequence rules and next prev/yellow-count values.
  always_comb begin
    prev_d  = prev_q;
    ycnt_d  = ycnt_q;
    active  = '0;
    invalid = '0;
    skip_y  = '0;
    short_y = '0;
    for (int i = 0; i < 10; i++) begin
      active[i]  = (ch_w[i] != RED);
      invalid[i] = (ch_w[i] == INVALID_COLOR);
      // An invalid sample keeps the last good color so the next legal sample is judged against it.
      if (!invalid[i]) prev_d[i] = ch_w[i];
    end
    for (int i = 0; i < 8; i++) begin
      if (!invalid[i]) begin
        if (prev_q[i] == GREEN && ch_w[i] == RED)    skip_y[i] = 1'b1;
        if (prev_q[i] == RED   && ch_w[i] == YELLOW) skip_y[i] = 1'b1;
        if (prev_q[i] == YELLOW && ch_w[i] == RED && ycnt_q[i] < YMAX) short_y[i] = 1'b1;
        if (ch_w[i] == YELLOW) begin
          if (prev_q[i] == YELLOW) begin
            ycnt_d[i] = (ycnt_q[i] < YMAX) ? ycnt_q[i] + YW'(1) : ycnt_q[i];
          end else begin
            ycnt_d[i] = YW'(1);
          end
        end else begin
          ycnt_d[i] = '0;
        end
      end
    end
  end

  // Conflict detection: a channel is involved if it is active with at least one active partner.
  always_comb begin
    conflict_hit = '0;
    for (int i = 0; i < 10; i++) begin
      conflict_hit[i] = active[i] & (|(active & conflict_mask(i)));
    end
    conflict     = |conflict_hit;
    // persist_q is 0 in MONITOR, so this also covers the CONFLICT_PERSIST == 1 case there.
    persist_done = (int'(persist_q) + 1) >= CONFLICT_PERSIST;
    all_red      = ~(|active);
    clear_done   = (state_q == S_CLEAR_WAIT) && all_red && ((int'(allred_q) + 1) >= ALL_RED_CLEAR);
  end

  // Event arbitration: invalid > persisted conflict > skipped yellow > short yellow, lowest channel wins.
  always_comb begin
    ev_code    = CODE_NONE;
    ev_channel = 4'd0;
    if (|invalid) begin
      ev_code    = CODE_INVALID;
      ev_channel = lowest_index(invalid);
    end else if (conflict && persist_done) begin
      ev_code    = CODE_CONFLICT;
      ev_channel = lowest_index(conflict_hit);
    end else if (|skip_y) begin
      ev_code    = CODE_SKIP_Y;
      ev_channel = lowest_index({2'b00, skip_y});
    end else if (|short_y) begin
      ev_code    = CODE_SHORT_Y;
      ev_channel = lowest_index({2'b00, short_y});
    end
  end

  // Color history: tracked in every state, reloaded to RED when monitoring resumes.
  always_ff @(posedge clk) begin
    if (reset || clear_done) begin
      prev_q <= '0;  // RED encodes as 0
      ycnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      ycnt_q <= ycnt_d;
    end
  end

  // Monitor state machine with registered fault outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_MONITOR;
      persist_q       <= '0;
      allred_q        <= '0;
      fault_q         <= 1'b0;
      flash_en_q      <= 1'b0;
      fault_code_q    <= CODE_NONE;
      fault_channel_q <= 4'd0;
      fault_count_q   <= 8'd0;
    end else begin
      case (state_q)
        S_MONITOR, S_PENDING: begin
          if (ev_code != CODE_NONE) begin
            state_q         <= S_FAULT;
            persist_q       <= '0;
            fault_q         <= 1'b1;
            flash_en_q      <= 1'b1;
            fault_code_q    <= ev_code;
            fault_channel_q <= ev_channel;
            if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
          end else if (conflict) begin
            state_q   <= S_PENDING;
            persist_q <= persist_q + PW'(1);
          end else begin
            state_q   <= S_MONITOR;
            persist_q <= '0;
          end
        end
        S_FAULT: begin
          if (mon.fault_clear) begin
            state_q  <= S_CLEAR_WAIT;
            allred_q <= '0;
          end
        end
        S_CLEAR_WAIT: begin
          if (clear_done) begin
            state_q         <= S_MONITOR;
            allred_q        <= '0;
            fault_q         <= 1'b0;
            flash_en_q      <= 1'b0;
            fault_code_q    <= CODE_NONE;
            fault_channel_q <= 4'd0;
          end else if (all_red) begin
            allred_q <= allred_q + AW'(1);
          end else begin
            allred_q <= '0;
          end
        end
        default: state_q <= S_MONITOR;
      endcase
    end
  end

  assign mon.flash_en      = flash_en_q;
  assign mon.fault         = fault_q;
  assign mon.fault_code    = fault_code_q;
  assign mon.fault_channel = fault_channel_q;
  assign mon.fault_count   = fault_count_q;

endmodule

// File: doc/traffic_signal_conflict_monitor.md
Name: traffic_signal_conflict_monitor

Overview:
- Independent watchdog (malfunction management unit) on the output side of traffic_signal_control_system.
- Samples all ten color_e signal outputs every clock and checks for conflicting right-of-way, illegal color sequences and short yellows.
- On a fault it latches a code and channel and asserts flash_en, which forces the intersection into flash.
- Runs on the same 1 Hz system clock; one cycle = 1 s.

Parameters:
- MIN_YELLOW, 3: minimum consecutive YELLOW cycles for a vehicle channel.
- CONFLICT_PERSIST, 2: consecutive cycles a conflict must hold before it latches.
- ALL_RED_CLEAR, 5: consecutive all-RED cycles required after fault_clear before monitoring resumes.

Ports:
- clk  input  1  system clock, 1 Hz
- reset  input  1  synchronous, active-high
- signal_sb, signal_sb_turn, signal_nb, signal_nb_turn  input  color_e  NS vehicle channels 0-3
- signal_wb, signal_wb_turn, signal_eb, signal_eb_turn  input  color_e  EW vehicle channels 4-7
- ped_signal_ns, ped_signal_ew  input  color_e  pedestrian channels 8, 9
- fault_clear  input  1  operator acknowledge, single-cycle pulse
- flash_en  output  1  force-flash command to the intersection
- fault  output  1  fault latched
- fault_code  output  3  0 none, 1 conflict, 2 skipped yellow, 3 short yellow, 4 invalid color
- fault_channel  output  4  lowest channel index involved in the latched fault
- fault_count  output  8  saturating count of latched faults since reset

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Colors come from traffic_signal_colors_pkg. "Active" means any value other than RED.
- Reset values: all outputs 0; state MONITOR; per-channel prev color RED; yellow counters 0; persist counter 0.
- Conflict pairs (combinational, evaluated each cycle):
  - Any NS vehicle channel (0-3) active together with any EW vehicle channel (4-7).
  - Turn channel active together with the opposing through: sb_turn/nb, nb_turn/sb, wb_turn/eb, eb_turn/wb.
  - ped_ns active together with any of channels 1, 3, 4-7.
  - ped_ew active together with any of channels 0-3, 5, 7.
- Sequence rules (vehicle channels 0-7 only; ped channels are exempt):
  - GREEN->RED is a skipped yellow, code 2.
  - RED->YELLOW is also code 2.
  - YELLOW->RED after fewer than MIN_YELLOW consecutive YELLOW cycles is a short yellow, code 3. The yellow counter saturates at MIN_YELLOW.
  - YELLOW->GREEN is legal.
- Any input outside RED/YELLOW/GREEN is invalid, code 4. This check applies to all 10 channels, latches immediately, and that channel's prev register is not updated.
- State machine:
  - MONITOR:
    - Code 2, 3 or 4 detected: go to FAULT, latching in the same edge.
    - Conflict present: persist counter = 1, go to PENDING (when CONFLICT_PERSIST = 1, latch directly).
  - PENDING:
    - Conflict still present: increment the counter. Reaching CONFLICT_PERSIST latches code 1 and goes to FAULT.
    - Conflict gone: counter = 0, return to MONITOR.
    - A code 2/3/4 event latches immediately and overrides.
  - FAULT:
    - fault = 1 and flash_en = 1; code and channel stay frozen.
    - fault_clear moves to CLEAR_WAIT.
  - CLEAR_WAIT:
    - flash_en stays 1. Count consecutive cycles with all 10 channels RED.
    - Reaching ALL_RED_CLEAR: fault, fault_code and fault_channel go to 0, prev registers are reloaded with RED, go to MONITOR.
    - Any non-RED resets the count.
    - fault_clear is ignored while in CLEAR_WAIT.
- Latency:
  - Sequence and invalid faults appear on outputs 1 cycle after the offending sample (registered).
  - Conflict faults appear CONFLICT_PERSIST cycles after first sample.
- Simultaneous events:
  - Priority is code 4 > 1 (persisted) > 2 > 3.
  - Within one code, the lowest channel index is reported.
  - For a conflict, fault_channel is the lowest index among the active conflicting channels.
- fault_count increments by 1 on each entry to FAULT and saturates at 255.
- Reset mid-fault returns everything to reset values within one edge.
- Prev-color registers update every cycle in every state, so no false sequence fault follows recovery.

Test Plan:
- Legal cycle: NS through GREEN 10 cycles, YELLOW 3, all RED 1, then EW through GREEN -> fault stays 0, flash_en 0 for 50 cycles.
- Conflict: signal_sb=GREEN and signal_wb=GREEN from cycle 20 -> fault_code=1, fault_channel=0, flash_en=1 at cycle 22. A one-cycle overlap at cycle 40 in a separate run -> no fault.
- Skipped yellow: signal_eb GREEN->RED at cycle 15 -> fault_code=2, fault_channel=6 at cycle 16, fault_count=1.
- Short yellow: signal_nb_turn YELLOW for 2 cycles then RED -> fault_code=3, fault_channel=3.
- Recovery: from FAULT, pulse fault_clear, then drive all RED 4 cycles, then 1 GREEN, then all RED 5 cycles -> flash_en stays 1 until the 5th consecutive all-RED edge, then fault=0 and fault_code=0.
- Simultaneous and reset: invalid value on ped_signal_ew (channel 9) in the same cycle as a GREEN->RED on signal_sb -> fault_code=4, fault_channel=9. Assert reset for 1 cycle -> all outputs 0, fault_count=0.
